separate56_act_sched: RTL

SEPARATE56_ACT_SCHED -- requirements
Module: separate56_act_sched

---
 rtl/separate56_act_sched.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/separate56_act_sched.sv
// Separate56 actuator scheduler: climate FSM with on/off dwell, door hold extension, buzzer staging.
// Optional macro SEPARATE56_ALARM_PREEMPT_EN lets alarm_req preempt and block climate drive.
module separate56_act_sched #(
  parameter int MIN_ON    = 8,
  parameter int MIN_OFF   = 4,
  parameter int DOOR_HOLD = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       heat_req,
  input  logic       cool_req,
  input  logic       fdoor_req,
  input  logic       rdoor_req,
  input  logic       winbuzz_req,
  input  logic       alarm_req,
  output logic       heater,
  output logic       cooler,
  output logic       fdoor,
  output logic       rdoor,
  output logic       winbuzz,
  output logic       alarmbuzz,
  output logic [1:0] climate_state,
  output logic       conflict
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2,
    DEAD = 2'd3
  } climate_t;

  localparam logic [7:0] ON_LAST   = 8'(MIN_ON - 1);
  localparam logic [7:0] OFF_LAST  = 8'(MIN_OFF - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(DOOR_HOLD);

  climate_t   state, state_nxt;
  logic [7:0] on_cnt, on_cnt_nxt;
  logic [7:0] off_cnt, off_cnt_nxt;
  logic [7:0] fhold, fhold_nxt;
  logic [7:0] rhold, rhold_nxt;
  logic       fdoor_q, rdoor_q;
  logic       dir_req;
  logic       preempt;

`ifdef SEPARATE56_ALARM_PREEMPT_EN
  assign preempt = alarm_req;
`else
  assign preempt = 1'b0;
`endif

  // Load on a sampled falling request, otherwise count down and stick at zero.
  function automatic logic [7:0] hold_next(input logic req, input logic req_q, input logic [7:0] hold);
    if (req_q && !req) begin
      return HOLD_LOAD;
    end else if (hold != 8'd0) begin
      return hold - 8'd1;
    end else begin
      return 8'd0;
    end
  endfunction

  always_comb begin
    state_nxt   = state;
    on_cnt_nxt  = on_cnt;
    off_cnt_nxt = off_cnt;
    dir_req     = (state == HEAT) ? heat_req : cool_req;
    case (state)
      IDLE: begin
        if (preempt) begin
          state_nxt = IDLE;
        end else if (heat_req) begin
          state_nxt  = HEAT;
          on_cnt_nxt = 8'd0;
        end else if (cool_req) begin
          state_nxt  = COOL;
          on_cnt_nxt = 8'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      HEAT, COOL: begin
        // Direction is locked until the drive has gone through DEAD.
        if (preempt || ((on_cnt == ON_LAST) && !dir_req)) begin
          state_nxt   = DEAD;
          off_cnt_nxt = 8'd0;
        end else if (on_cnt != ON_LAST) begin
          on_cnt_nxt = on_cnt + 8'd1;
        end else begin
          on_cnt_nxt = on_cnt;
        end
      end
      DEAD: begin
        if (off_cnt == OFF_LAST) begin
          state_nxt   = IDLE;
          off_cnt_nxt = 8'd0;
        end else begin
          off_cnt_nxt = off_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    fhold_nxt = hold_next(fdoor_req, fdoor_q, fhold);
    rhold_nxt = hold_next(rdoor_req, rdoor_q, rhold);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      on_cnt    <= 8'd0;
      off_cnt   <= 8'd0;
      fhold     <= 8'd0;
      rhold     <= 8'd0;
      fdoor_q   <= 1'b0;
      rdoor_q   <= 1'b0;
      heater    <= 1'b0;
      cooler    <= 1'b0;
      fdoor     <= 1'b0;
      rdoor     <= 1'b0;
      winbuzz   <= 1'b0;
      alarmbuzz <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      state     <= state_nxt;
      on_cnt    <= on_cnt_nxt;
      off_cnt   <= off_cnt_nxt;
      fhold     <= fhold_nxt;
      rhold     <= rhold_nxt;
      fdoor_q   <= fdoor_req;
      rdoor_q   <= rdoor_req;
      heater    <= (state_nxt == HEAT);
      cooler    <= (state_nxt == COOL);
      fdoor     <= fdoor_req | (fhold_nxt != 8'd0);
      rdoor     <= rdoor_req | (rhold_nxt != 8'd0);
      winbuzz   <= winbuzz_req;
      alarmbuzz <= alarm_req;
      conflict  <= heat_req & cool_req;
    end
  end

  assign climate_state = state;

endmodule
